// File: rtl/fib_term_collector_if.sv
// Stream bundle between the Fibonacci generator, the term collector
// and the downstream consumer of tagged terms.
interface fib_term_collector_if #(
    parameter int N     = 8,
    parameter int IDX_W = 6
);
    logic [N-1:0]     in_data;
    logic             in_valid;
    logic [N-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_ovf,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_ovf,
        output out_valid
    );
endinterface

// File: rtl/fib_term_collector.sv
// Tags generator terms with index and wrap flag, queues them in a
// first-word-fall-through FIFO; terms arriving while full are dropped.
module fib_term_collector #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    fib_term_collector_if.slave    bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt,
    output logic                   ovf_seen
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    typedef struct packed {
        logic [N-1:0]     data;
        logic [IDX_W-1:0] idx;
        logic             ovf;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW:0]      r_count;
    logic [7:0]       r_drop;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_prev;
    logic             r_seen;

    logic   w_push;
    logic   w_pop;
    logic   w_full;
    logic   w_wr;
    logic   w_drop;
    logic   w_wrap;
    logic   w_nempty;
    entry_t w_new;
    entry_t w_head;

    always_comb begin
        w_nempty = (r_count != '0);
        w_full   = (r_count == FULL);
        w_push   = bus.in_valid & ~clear;
        w_pop    = w_nempty & bus.out_ready & ~clear;
        // A full FIFO still accepts when the head leaves this cycle
        w_wr     = w_push & (~w_full | w_pop);
        w_drop   = w_push & w_full & ~w_pop;
        w_wrap   = (r_idx != '0) && (bus.in_data < r_prev);
        w_new.data = bus.in_data;
        w_new.idx  = r_idx;
        w_new.ovf  = w_wrap | r_seen;
        w_head   = r_mem[r_rd];
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_idx   <= '0;
            r_prev  <= '0;
            r_seen  <= 1'b0;
        end else if (clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_idx   <= '0;
            r_prev  <= '0;
            r_seen  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop != 8'hFF) begin
                r_drop <= r_drop + 1'b1;
            end
            if (w_push) begin
                r_prev <= bus.in_data;
                if (r_idx != IDX_MAX) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_wrap) begin
                    r_seen <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = w_nempty;
    assign bus.out_data  = w_nempty ? w_head.data : '0;
    assign bus.out_idx   = w_nempty ? w_head.idx : '0;
    assign bus.out_ovf   = w_nempty ? w_head.ovf : 1'b0;
    assign count         = r_count;
    assign drop_cnt      = r_drop;
    assign ovf_seen      = r_seen;
endmodule

// File: doc/fib_term_collector.md
Name: fib_term_collector

Overview:
- Downstream consumer of the Fibonacci generator stage.
- Captures each strobed term (generator `fib_out` + `done`) and tags it with its sequence index and an N-bit wrap (overflow) flag.
- Buffers tagged terms in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the next consumer.
- The generator has no backpressure, so terms arriving while the FIFO is full are dropped and counted.

Parameters:
- N, 8, width of each term; must match the generator's N.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- IDX_W, 6, width of the term index.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush; wired to the generator's `start`.
- in_data  input  N  term value; wired to `fib_out`.
- in_valid  input  1  term strobe; wired to `done`.
- out_data  output  N  head-of-FIFO term.
- out_idx  output  IDX_W  sequence index of the head term (first term after clear is index 0).
- out_ovf  output  1  head term is at or after the first wrap.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head term.
- count  output  clog2(DEPTH)+1  occupancy.
- drop_cnt  output  8  dropped terms since clear; saturates at 255.
- ovf_seen  output  1  sticky: a wrap was detected since clear.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, out_valid=0, count=0, drop_cnt=0, ovf_seen=0, term index=0, prev=0. FIFO storage is not reset; out_data, out_idx and out_ovf read 0 while empty.
- Push: an in_valid cycle with clear low.
  - Entry written = {in_data, idx, ovf}.
  - idx increments on every push, including dropped ones. It saturates at 2^IDX_W-1.
  - prev <= in_data on every push, including dropped ones.
- Wrap detection: for idx ≥ 1, in_data < prev ⇒ wrap.
  - Entry ovf = wrap OR ovf_seen.
  - ovf_seen is set on the cycle the wrap term is pushed, and is visible the following cycle.
  - Index 0 is never flagged.
- Pop: out_valid & out_ready; the head advances next cycle.
- Latency: a pushed term appears on out_* one cycle after the in_valid edge (registered write, FWFT read).
- Full:
  - Push without a same-cycle pop ⇒ term dropped; drop_cnt +1 (saturating).
  - Push with a same-cycle pop ⇒ accepted; count unchanged.
- Empty: out_ready is ignored; no underflow; count stays 0.
- Simultaneous push and pop when non-empty: both occur; count unchanged.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- clear (priority over push and pop):
  - Next cycle: FIFO empty, idx=0, prev=0, ovf_seen=0, drop_cnt=0.
  - in_valid and out_ready in the clear cycle are ignored.
- rst_n asserted mid-stream: immediate return to reset state; no partial entry survives.
- Width: index and drop counters saturate and never wrap. The wrap comparison is unsigned N-bit.

Test Plan:
- Reset, then clear, then 8 strobes 0,1,1,2,3,5,8,13 with out_ready=1 ⇒ out_data 0,1,1,2,3,5,8,13 with out_idx 0..7, each one cycle after its strobe; out_ovf=0; drop_cnt=0.
- N=8, 16 consecutive terms with out_ready=1:
  - Terms F13=233, F14=121 (377 mod 256), F15=98 (610 mod 256) appear in order.
  - idx 14 has out_ovf=1 (121<233); idx 15 has out_ovf=1 (sticky).
  - ovf_seen rises the cycle after idx 14 is pushed; idx 0..13 have ovf=0.
- DEPTH=4, out_ready=0, 7 strobes ⇒ count=4, drop_cnt=3. Then out_ready=1 ⇒ idx 0,1,2,3 drain, out_valid falls after 4 pops; next strobe carries idx 7.
- FIFO full with out_ready=1 and in_valid=1 in the same cycle ⇒ count stays 4, drop_cnt unchanged, new term is at the tail.
- clear asserted mid-stream with 3 entries queued, and in_valid=1 in the same cycle ⇒ next cycle out_valid=0, count=0, drop_cnt=0, ovf_seen=0; next strobe carries idx 0.
- rst_n pulsed low asynchronously, between clock edges, while FIFO holds 2 entries ⇒ out_valid=0 and count=0 immediately; index restarts at 0 on the next strobe after release.
